// File: rtl/cache_stats_reader.sv
// ---------------------------------------------------------------------------
// cache_stats_reader
//
// Sweeps the cache statistics counters held in the performance controller.
// Each record is a 64-bit counter. The block reads it as two 32-bit words
// (lo then hi) through a select/return word pair. It presents each assembled
// record on a valid/ready stream and pulses done_o once the last record has
// been accepted.
//
// Counting in the controller is controlled by comm_o[24]. It follows the host
// enable_i. With FREEZE_ON_READ=1 it is forced low for the whole sweep, so the
// records of one sweep form a consistent snapshot.
//
// Configuration macro: DATA_POLICY_DLEASE_STATS_EN
//   defined   : 9 records (0..8), adds the lease statistics
//               (expired, defaulted, multi-expired, default-misses, random
//               evictions)
//   undefined : 4 records (0..3): hits, misses, writebacks, walltime
//
// Parameters
//   READ_LATENCY    cycles a select is held before the returned word is
//                   captured (1..15)
//   FREEZE_ON_READ  1: suspend counting while a sweep is in progress
//
// Ports
//   clock_i               rising-edge clock
//   reset_i               synchronous, active-high reset
//   enable_i              host request for statistics counting
//   start_i               one-cycle pulse, starts a sweep (ignored while busy)
//   comm_o[31:0]          controller config word: [4:0] word select,
//                         [24] count enable, other bits 0
//   comm_i[31:0]          statistics word returned by the controller
//   select_data_record_o  record-path select, fixed to the statistics path
//   data_o[63:0]          assembled counter {hi word, lo word}
//   index_o[3:0]          record number of data_o
//   valid_o / ready_i     record handshake, transfer when both are high
//   busy_o                sweep in progress
//   done_o                one-cycle pulse when a sweep completes
// ---------------------------------------------------------------------------
module cache_stats_reader #(
  parameter int unsigned READ_LATENCY   = 2,
  parameter bit          FREEZE_ON_READ = 1'b1
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic        start_i,
  output logic [31:0] comm_o,
  input  logic [31:0] comm_i,
  output logic [1:0]  select_data_record_o,
  output logic [63:0] data_o,
  output logic [3:0]  index_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        busy_o,
  output logic        done_o
);

`ifdef DATA_POLICY_DLEASE_STATS_EN
  localparam logic [3:0] LAST_RECORD = 4'd8;
`else
  localparam logic [3:0] LAST_RECORD = 4'd3;
`endif

  // Latency counter reload value. The counter runs READ_LATENCY-1 down to 0,
  // so a legal latency (max 15) never needs more than 4 bits.
  localparam logic [3:0] LAT_RELOAD = 4'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEL_LO,
    SEL_HI,
    PUSH,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  rec_q, rec_d;
  logic [3:0]  lat_q;
  logic [4:0]  sel_d;
  logic [31:0] comm_d;

  // Word select of the lo half of a record; the hi half is always lo+1.
  // Records 0..6 are packed pairs starting at word 0. Words 14/15 are not
  // statistics, so records 7 and 8 skip over them (16/17, 18/19).
  function automatic logic [4:0] lo_select(input logic [3:0] rec);
    logic [4:0] sel;
    sel = {rec, 1'b0};
`ifdef DATA_POLICY_DLEASE_STATS_EN
    if (rec >= 4'd7) begin
      sel = sel + 5'd2;
    end
`endif
    return sel;
  endfunction

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    rec_d   = rec_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SEL_LO;
          rec_d   = '0;
        end
      end
      SEL_LO: begin
        if (lat_q == 4'd0) state_d = SEL_HI;
      end
      SEL_HI: begin
        if (lat_q == 4'd0) state_d = PUSH;
      end
      PUSH: begin
        if (ready_i) begin
          if (rec_q == LAST_RECORD) begin
            state_d = DONE;
          end else begin
            state_d = SEL_LO;
            rec_d   = rec_q + 4'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // comm_o is registered from the next state. The select then changes in
  // the same cycle the FSM enters a select state, which starts the latency
  // window on time. Reset also clears comm_o.
  // The hi select is held through PUSH. The controller keeps returning the
  // same word while the consumer stalls.
  always_comb begin
    sel_d = '0;
    case (state_d)
      SEL_LO:       sel_d = lo_select(rec_d);
      SEL_HI, PUSH: sel_d = lo_select(rec_d) | 5'd1;
      default:      sel_d = '0;
    endcase

    comm_d      = '0;
    comm_d[4:0] = sel_d;
    comm_d[24]  = enable_i && !((state_d != IDLE) && FREEZE_ON_READ);
  end

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock_i) begin
    // NOTE: non-blocking assignments here. All registers then update together
    // from the values of the previous cycle, no matter how statements are ordered.
    if (reset_i) begin
      state_q <= IDLE;
      rec_q   <= '0;
      lat_q   <= '0;
      comm_o  <= '0;
      data_o  <= '0;
      index_o <= '0;
    end else begin
      state_q <= state_d;
      rec_q   <= rec_d;
      comm_o  <= comm_d;

      // Reload whenever a new select is about to be driven; otherwise count
      // down and hold at zero so the counter cannot wrap while waiting.
      if ((state_d != state_q) && ((state_d == SEL_LO) || (state_d == SEL_HI))) begin
        lat_q <= LAT_RELOAD;
      end else if (lat_q != 4'd0) begin
        lat_q <= lat_q - 4'd1;
      end

      if ((state_q == SEL_LO) && (lat_q == 4'd0)) begin
        data_o[31:0] <= comm_i;
      end
      if ((state_q == SEL_HI) && (lat_q == 4'd0)) begin
        data_o[63:32] <= comm_i;
        index_o       <= rec_q;
      end
    end
  end

  // -------------------------------------------------------------------------
  // State-decoded outputs
  // -------------------------------------------------------------------------
  assign select_data_record_o = 2'b00;
  assign valid_o              = (state_q == PUSH);
  assign busy_o               = (state_q != IDLE);
  assign done_o               = (state_q == DONE);

endmodule

// File: tb/tb_cache_stats_reader.sv
// ---------------------------------------------------------------------------
// tb_cache_stats_reader
//
// Self-checking bench for cache_stats_reader at READ_LATENCY=2, FREEZE_ON_READ=1.
// Works with or without DATA_POLICY_DLEASE_STATS_EN (record count follows it).
//
// The performance controller is modelled as a word array. A returned word is
// only valid once its select has been held READ_LATENCY cycles; before that
// the model returns 32'hDEAD_BEEF, so a capture made too early shows up as
// wrong data. Expected records come from the statistics word map and the word
// array.
// ---------------------------------------------------------------------------
module tb_cache_stats_reader;

  localparam int L = 2;
`ifdef DATA_POLICY_DLEASE_STATS_EN
  localparam int N = 9;
`else
  localparam int N = 4;
`endif
  localparam int REC_CYC   = 2 * L + 1;
  localparam int SWEEP_CYC = N * REC_CYC + 1;
  localparam int LO_SEL [9] = '{0, 2, 4, 6, 8, 10, 12, 16, 18};
  localparam int MAX_SEL   = LO_SEL[N-1] + 1;
  localparam int INJ_REC   = (N > 4) ? 4 : 2;
  localparam int RST_REC   = (N > 5) ? 5 : 2;

  logic        clock_i = 1'b0;
  logic        reset_i, enable_i, start_i, ready_i;
  logic [31:0] comm_o, comm_i;
  logic [1:0]  select_data_record_o;
  logic [63:0] data_o;
  logic [3:0]  index_o;
  logic        valid_o, busy_o, done_o;

  logic [31:0] word_mem [32];
  logic [63:0] rx_data  [16];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  cache_stats_reader #(
    .READ_LATENCY  (L),
    .FREEZE_ON_READ(1'b1)
  ) dut (
    .clock_i             (clock_i),
    .reset_i             (reset_i),
    .enable_i            (enable_i),
    .start_i             (start_i),
    .comm_o              (comm_o),
    .comm_i              (comm_i),
    .select_data_record_o(select_data_record_o),
    .data_o              (data_o),
    .index_o             (index_o),
    .valid_o             (valid_o),
    .ready_i             (ready_i),
    .busy_o              (busy_o),
    .done_o              (done_o)
  );

  always #5 clock_i = ~clock_i;
  always @(posedge clock_i) cyc <= cyc + 1;

  // Controller model: age counts how many cycles the current select has
  // already been held before this one.
  logic [4:0] last_sel = '0;
  int         run_len  = 0;
  int         age;
  assign age    = (comm_o[4:0] == last_sel) ? run_len + 1 : 0;
  assign comm_i = (age >= L - 1) ? word_mem[comm_o[4:0]] : 32'hDEAD_BEEF;
  always @(posedge clock_i) begin
    last_sel <= comm_o[4:0];
    run_len  <= age;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] exp_record(input int r);
    return {word_mem[LO_SEL[r] + 1], word_mem[LO_SEL[r]]};
  endfunction

  task automatic wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      if (done_o) seen = 1'b1;
      else tick();
    end
  endtask

  // One sweep with a scoreboard. ready_i is high with probability ready_pct.
  // If inject_at >= 0, a stray start_i pulse is driven that many cycles after
  // the start cycle.
  task automatic do_sweep(input int ready_pct, input int inject_at, input string tag);
    int t_start, t_done, got, busy_bad, cnt_bad, sel_bad, extra_done, extra_busy;
    bit seen_done;
    got = 0; t_done = 0; seen_done = 1'b0;
    busy_bad = 0; cnt_bad = 0; sel_bad = 0; extra_done = 0; extra_busy = 0;

    start_i = 1'b1;
    t_start = cyc;
    tick();
    for (int k = 1; k < 4000 && !seen_done; k++) begin
      start_i = (k == inject_at);
      if (busy_o !== 1'b1) busy_bad++;
      if (comm_o[24] !== 1'b0) cnt_bad++;
      if (int'(comm_o[4:0]) > MAX_SEL) sel_bad++;
      if (done_o) begin
        seen_done = 1'b1;
        t_done    = cyc;
      end else begin
        ready_i = ($urandom_range(99) < ready_pct);
        if (valid_o && ready_i) begin
          if (got < N) begin
            check($sformatf("%s rec%0d index", tag, got), 64'(index_o), 64'(got));
            check($sformatf("%s rec%0d data", tag, got), data_o, exp_record(got));
          end
          rx_data[index_o] = data_o;
          got++;
        end
        tick();
      end
    end
    start_i = 1'b0;
    ready_i = 1'b0;

    check({tag, " done seen"}, 64'(seen_done), 64'(1));
    check({tag, " record count"}, 64'(got), 64'(N));
    if (ready_pct >= 100)
      check({tag, " start-to-done cycles"}, 64'(t_done - t_start), 64'(SWEEP_CYC));
    check({tag, " busy low mid-sweep"}, 64'(busy_bad), 64'(0));
    check({tag, " count enable not frozen"}, 64'(cnt_bad), 64'(0));
    check({tag, " select out of range"}, 64'(sel_bad), 64'(0));

    tick();
    check({tag, " done width"}, 64'(done_o), 64'(0));
    check({tag, " busy after done"}, 64'(busy_o), 64'(0));
    check({tag, " count enable after done"}, 64'(comm_o[24]), 64'(enable_i));
    for (int k = 0; k < 3 * REC_CYC; k++) begin
      tick();
      if (done_o) extra_done++;
      if (busy_o) extra_busy++;
    end
    check({tag, " extra done pulses"}, 64'(extra_done), 64'(0));
    check({tag, " busy while idle"}, 64'(extra_busy), 64'(0));
  endtask

  typedef struct {
    logic        rst, en, st, rdy;
    logic        busy, valid, done;
    logic [31:0] comm;
    logic        chk_data;
    logic [63:0] data;
  } vec_t;

  localparam logic [31:0] CE = 32'h0100_0000;
  localparam logic [63:0] R0 = 64'hA000_0001_A000_0000;

  initial begin
    vec_t vecs [13];
    bit          seen, found;
    int          stall_bad, quiet_bad;
    logic [63:0] held;

    // Each row: inputs applied for one cycle, outputs expected after that edge.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 64'h0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 64'h0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CE,    1'b0, 64'h0};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 64'h0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 64'h0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0, 64'h0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1, 1'b0, 64'h0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1, 1'b1, R0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1, 1'b1, R0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h2, 1'b0, 64'h0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h2, 1'b0, 64'h0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 64'h0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CE,    1'b0, 64'h0};

    for (int i = 0; i < 32; i++) word_mem[i] = 32'hA000_0000 + 32'(i);
    reset_i = 1'b1; enable_i = 1'b0; start_i = 1'b0; ready_i = 1'b0;
    tick();
    tick();

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 13; i++) begin
      reset_i  = vecs[i].rst;
      enable_i = vecs[i].en;
      start_i  = vecs[i].st;
      ready_i  = vecs[i].rdy;
      tick();
      check($sformatf("vec%0d busy", i),  64'(busy_o),  64'(vecs[i].busy));
      check($sformatf("vec%0d valid", i), 64'(valid_o), 64'(vecs[i].valid));
      check($sformatf("vec%0d done", i),  64'(done_o),  64'(vecs[i].done));
      check($sformatf("vec%0d comm", i),  64'(comm_o),  64'(vecs[i].comm));
      check($sformatf("vec%0d record path", i), 64'(select_data_record_o), 64'(0));
      if (vecs[i].chk_data) begin
        check($sformatf("vec%0d data", i),  data_o, vecs[i].data);
        check($sformatf("vec%0d index", i), 64'(index_o), 64'(0));
      end
    end
    reset_i = 1'b0; start_i = 1'b0; ready_i = 1'b0;

    // ---------------- full sweep, ready always high ----------------
    check("idle count enable", 64'(comm_o[24]), 64'(1));
    do_sweep(100, -1, "full");
`ifdef DATA_POLICY_DLEASE_STATS_EN
    check("record 7 value", rx_data[7], 64'hA000_0011_A000_0010);
`else
    check("record 3 value", rx_data[3], 64'hA000_0007_A000_0006);
`endif

    // ---------------- consumer stall on record 2 ----------------
    ready_i = 1'b1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      if (valid_o && index_o == 4'd2) found = 1'b1;
      else tick();
    end
    ready_i = 1'b0;
    check("stall reached record 2", 64'(found), 64'(1));
    check("stall record 2 data", data_o, exp_record(2));
    held = data_o;
    stall_bad = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (valid_o !== 1'b1 || data_o !== held || index_o !== 4'd2 || comm_o[4:0] !== 5'd5)
        stall_bad++;
    end
    check("stall outputs held", 64'(stall_bad), 64'(0));
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check("select after accept", 64'(comm_o[4:0]), 64'(6));
    check("valid after accept", 64'(valid_o), 64'(0));
    ready_i = 1'b1;
    wait_done(20 * REC_CYC, seen);
    ready_i = 1'b0;
    check("stall sweep done", 64'(seen), 64'(1));
    tick();
    tick();

    // ---------------- stray start mid-sweep ----------------
    do_sweep(100, INJ_REC * REC_CYC + 2, "inject");

    // ---------------- reset during SEL_HI ----------------
    ready_i = 1'b1; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 1; k < RST_REC * REC_CYC + L + 1; k++) tick();
    check("pre-reset hi select", 64'(comm_o[4:0]), 64'(LO_SEL[RST_REC] + 1));
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    ready_i = 1'b0;
    check("reset busy", 64'(busy_o), 64'(0));
    check("reset valid", 64'(valid_o), 64'(0));
    check("reset comm", 64'(comm_o), 64'(0));
    check("reset done", 64'(done_o), 64'(0));
    quiet_bad = 0;
    for (int k = 0; k < 3 * REC_CYC; k++) begin
      tick();
      if (done_o || busy_o || valid_o) quiet_bad++;
    end
    check("no resume after reset", 64'(quiet_bad), 64'(0));
    do_sweep(100, -1, "post-reset");

    // ---------------- randomized sweeps ----------------
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < 32; i++) word_mem[i] = $urandom;
      enable_i = 1'($urandom_range(1));
      tick();
      check($sformatf("rand%0d idle count enable", s), 64'(comm_o[24]), 64'(enable_i));
      do_sweep((s == 0) ? 100 : int'($urandom_range(100, 25)), -1, $sformatf("rand%0d", s));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
